// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM encoding shared by the UART transmitter and receiver.
package uart_pkg;
   localparam int DATA_BITS        = 8;
   localparam int CLKS_PER_BIT_DEF = 868;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: multi-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[STAGES-2:0], d};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= {STAGES{RST_VAL}};
      else        sync_q <= sync_d;
   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, optional even parity, valid/ready holding register.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter bit PARITY_EN    = 1'b0,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk_uart,
   input  logic       areset_uart,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun,
   output logic       busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
   logic                 par_q, par_d, prev_q, valid_q, valid_d;
   logic                 ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
   logic                 rxs, fall, commit, hs;

   sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
      .clk(clk_uart), .rst_n(areset_uart), .d(rx), .q(rxs)
   );

   // prev_q tracks rxs in every state, so a line still low when IDLE is re-entered never counts as an edge
   assign fall = prev_q & ~rxs;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - CW'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: if (fall) begin
            state_d = START;
            cnt_d   = HALF;
         end
         START: if (cnt_q == '0) begin
            state_d = rxs ? IDLE : DATA;
            cnt_d   = FULL;
            idx_d   = '0;
            par_d   = 1'b0;
         end
         DATA: if (cnt_q == '0) begin
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            cnt_d   = FULL;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'(DATA_BITS - 1)) state_d = PARITY_EN ? PARITY : STOP;
         end
         PARITY: if (cnt_q == '0) begin
            par_d   = ^shift_q ^ rxs;
            cnt_d   = FULL;
            state_d = STOP;
         end
         STOP: if (cnt_q == '0) begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hs      = valid_q & rx_ready;
      valid_d = commit | (valid_q & ~rx_ready);
      data_d  = commit ? shift_q : data_q;
      ferr_d  = commit ? ~rxs : ferr_q;
      perr_d  = commit ? (PARITY_EN & par_q) : perr_q;
      ovr_d   = (commit & valid_q & ~hs) | (ovr_q & ~hs);
   end

   always_ff @(posedge clk_uart or negedge areset_uart)
      if (!areset_uart) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         prev_q  <= 1'b1;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         prev_q  <= rxs;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
         ovr_q   <= ovr_d;
      end

   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign frame_err  = ferr_q;
   assign parity_err = perr_q;
   assign overrun    = ovr_q;
   assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench; dut0 is 8N1, dut1 expects even parity, both 16 clocks per bit.
module tb_uart_rx;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0_n, rst1_n, rx0, rx1, rdy0, rdy1;
   logic [7:0] d0, d1;
   logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;
   int         n_cmp = 0, n_err = 0, nv0 = 0, nv1 = 0, snap;
   logic [10:0] q0[$], q1[$];

   uart_rx #(.CLKS_PER_BIT(16), .PARITY_EN(1'b0), .SYNC_STAGES(2)) dut0 (
      .clk_uart(clk), .areset_uart(rst0_n), .rx(rx0), .rx_data(d0), .rx_valid(v0),
      .rx_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(b0)
   );
   uart_rx #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1), .SYNC_STAGES(2)) dut1 (
      .clk_uart(clk), .areset_uart(rst1_n), .rx(rx1), .rx_data(d1), .rx_valid(v1),
      .rx_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(b1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit u, input logic v);
      if (u) rx1 = v;
      else   rx0 = v;
   endtask

   task automatic send(input bit u, input logic [7:0] b, input bit pen, input logic p, input logic stp);
      drive(u, 1'b0);
      tick(16);
      for (int i = 0; i < 8; i++) begin
         drive(u, b[i]);
         tick(16);
      end
      if (pen) begin
         drive(u, p);
         tick(16);
      end
      drive(u, stp);
      tick(16);
   endtask

   // expected entries are {data, frame_err, parity_err, overrun}, popped on each handshake
   initial begin
      rst0_n = 1'b0; rst1_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
      fork
         forever begin
            @(negedge clk);
            if (v0) nv0++;
            if (v1) nv1++;
            if (v0 && rdy0) begin
               if (q0.size() == 0) chk("hs0_unexpected", {21'b0, d0, fe0, pe0, ov0}, 32'hFFFF_FFFF);
               else chk("hs0", {21'b0, d0, fe0, pe0, ov0}, {21'b0, q0.pop_front()});
            end
            if (v1 && rdy1) begin
               if (q1.size() == 0) chk("hs1_unexpected", {21'b0, d1, fe1, pe1, ov1}, 32'hFFFF_FFFF);
               else chk("hs1", {21'b0, d1, fe1, pe1, ov1}, {21'b0, q1.pop_front()});
            end
         end
      join_none
      tick(3);
      chk("reset0_outputs", {20'b0, d0, v0, fe0, pe0, ov0, b0}, 32'h0);
      chk("reset1_outputs", {20'b0, d1, v1, fe1, pe1, ov1, b1}, 32'h0);
      rst0_n = 1'b1; rst1_n = 1'b1;
      tick(5);

      q0.push_back({8'hA5, 3'b000});
      send(0, 8'hA5, 0, 1'b0, 1'b1);
      tick(20);
      chk("nominal_valid_cycles", nv0, 1);
      chk("nominal_pending", q0.size(), 0);

      q0.push_back({8'h00, 3'b000});
      q0.push_back({8'hFF, 3'b000});
      q0.push_back({8'h3C, 3'b000});
      send(0, 8'h00, 0, 1'b0, 1'b1);
      send(0, 8'hFF, 0, 1'b0, 1'b1);
      send(0, 8'h3C, 0, 1'b0, 1'b1);
      tick(20);
      chk("b2b_pending", q0.size(), 0);
      chk("b2b_valid_cycles", nv0, 4);

      q0.push_back({8'h55, 3'b100});
      send(0, 8'h55, 0, 1'b0, 1'b0);
      drive(0, 1'b1);
      tick(16);
      q0.push_back({8'h12, 3'b000});
      send(0, 8'h12, 0, 1'b0, 1'b1);
      tick(20);
      chk("frame_err_pending", q0.size(), 0);

      snap = nv0;
      drive(0, 1'b0);
      tick(4);
      drive(0, 1'b1);
      chk("glitch_busy_high", b0, 1);
      tick(9);
      chk("glitch_busy_low", b0, 0);
      tick(20);
      chk("glitch_no_valid", nv0, snap);

      rdy0 = 1'b0;
      send(0, 8'h11, 0, 1'b0, 1'b1);
      send(0, 8'h22, 0, 1'b0, 1'b1);
      tick(20);
      chk("ovr_valid", v0, 1);
      chk("ovr_data", d0, 8'h22);
      chk("ovr_flag", ov0, 1);
      q0.push_back({8'h22, 3'b001});
      rdy0 = 1'b1;
      tick(1);
      rdy0 = 1'b0;
      tick(2);
      chk("ovr_valid_cleared", v0, 0);
      chk("ovr_flag_cleared", ov0, 0);
      chk("ovr_pending", q0.size(), 0);

      q1.push_back({8'h07, 3'b000});
      send(1, 8'h07, 1, 1'b1, 1'b1);
      tick(20);
      q1.push_back({8'h07, 3'b010});
      send(1, 8'h07, 1, 1'b0, 1'b1);
      tick(20);
      chk("parity_pending", q1.size(), 0);
      chk("parity_err_latched", pe1, 1);

      snap = nv1;
      drive(1, 1'b0);
      tick(16);
      for (int i = 0; i < 4; i++) begin
         drive(1, i < 3);
         tick(16);
      end
      drive(1, 1'b0);
      tick(8);
      chk("midframe_busy", b1, 1);
      rst1_n = 1'b0;
      #1;
      chk("midframe_reset_outputs", {20'b0, d1, v1, fe1, pe1, ov1, b1}, 32'h0);
      drive(1, 1'b1);
      tick(20);
      rst1_n = 1'b1;
      tick(200);
      chk("after_reset_no_valid", nv1, snap);

      for (int i = 0; i < 500 && (q0.size() != 0 || q1.size() != 0); i++) tick(1);
      chk("final_pending0", q0.size(), 0);
      chk("final_pending1", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
